// File: rtl/result_uart_tx.sv
// Latches per-pose judgements, keeps a saturating score and sends a 4-byte ASCII report over UART.
// Optional even parity (8E1) is enabled by defining RESULT_UART_PARITY_EN; default is 8N1.
//
// state  | meaning
// IDLE   | line idle, waiting for uart_start, clear_score honoured here
// LOAD   | freeze {letter, tens, ones, LF} into the frame buffer
// START  | start bit of current byte
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (RESULT_UART_PARITY_EN only)
// STOP   | stop bit, then next byte or back to IDLE
module result_uart_tx #(
  parameter int BAUD_DIV    = 1289,
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1,
  parameter int SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] result,
  input  logic       uart_start,
  input  logic       clear_score,
  output logic       tx,
  output logic       busy,
  output logic [6:0] score,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PEN  = CW'(BAUD_DIV - 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [7:0]    INC_P     = 8'(PTS_PERFECT);
  localparam logic [7:0]    INC_G     = 8'(PTS_GOOD);
  localparam logic [7:0]    MAX8      = 8'(SCORE_MAX);
  localparam logic [6:0]    MAX7      = 7'(SCORE_MAX);

`ifdef RESULT_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    shreg;
  logic [7:0]    letter;
  logic [7:0]    frame [4];
`ifdef RESULT_UART_PARITY_EN
  logic          par_bit;
`endif

  logic [7:0] inc;
  logic [7:0] letter_d;
  logic [7:0] base;
  logic [7:0] sum;
  logic [6:0] next_score;
  logic [6:0] tens;
  logic [6:0] ones;

  always_comb begin
    inc      = 8'd0;
    letter_d = 8'h3F;
    case (result)
      3'b100: begin
        letter_d = 8'h50;
        inc      = INC_P;
      end
      3'b010: begin
        letter_d = 8'h47;
        inc      = INC_G;
      end
      3'b001: begin
        letter_d = 8'h42;
        inc      = 8'd0;
      end
      default: begin
        letter_d = 8'h3F;
        inc      = 8'd0;
      end
    endcase
    // a simultaneous clear zeroes the base before the increment lands
    base       = clear_score ? 8'd0 : {1'b0, score};
    sum        = base + inc;
    next_score = (sum > MAX8) ? MAX7 : sum[6:0];
  end

  // digits come from the already-updated score register during LOAD
  always_comb begin
    tens = score / 7'd10;
    ones = score - tens * 7'd10;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      letter   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      score    <= '0;
      overrun  <= 1'b0;
      for (int i = 0; i < 4; i++) frame[i] <= '0;
`ifdef RESULT_UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      overrun <= uart_start && busy;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (uart_start) begin
            state  <= LOAD;
            busy   <= 1'b1;
            letter <= letter_d;
            score  <= next_score;
          end else if (clear_score) begin
            score <= '0;
          end
        end
        LOAD: begin
          frame[0] <= letter;
          frame[1] <= 8'h30 + {1'b0, tens};
          frame[2] <= 8'h30 + {1'b0, ones};
          frame[3] <= 8'h0A;
          byte_idx <= '0;
          bit_idx  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= frame[byte_idx][0];
            shreg    <= {1'b0, frame[byte_idx][7:1]};
`ifdef RESULT_UART_PARITY_EN
            par_bit  <= ^frame[byte_idx];
`endif
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef RESULT_UART_PARITY_EN
              tx      <= par_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`ifdef RESULT_UART_PARITY_EN
        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          // last stop bit: its final cycle is spent in IDLE (tx still high) so a new strobe can land there
          if (byte_idx == 2'd3 && baud_cnt == BAUD_PEN) begin
            baud_cnt <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            byte_idx <= byte_idx + 2'd1;
            tx       <= 1'b0;
            state    <= START;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: table of judgements plus overrun, reset-abort and saturation sequences,
// with a UART receiver popping expected bytes from a scoreboard queue.
module tb_result_uart_tx;

  localparam int B = 8;
`ifdef RESULT_UART_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME_CYC = 4 * BITS * B;

  logic       clk;
  logic       reset;
  logic [2:0] result;
  logic       uart_start;
  logic       clear_score;
  logic       tx;
  logic       busy;
  logic [6:0] score;
  logic       overrun;

  result_uart_tx #(.BAUD_DIV(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .result     (result),
    .uart_start (uart_start),
    .clear_score(clear_score),
    .tx         (tx),
    .busy       (busy),
    .score      (score),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] sbq [$];
  bit         mon_en = 1'b0;
  int         model_score = 0;

  typedef struct {
    logic [2:0] res;
    logic       clr;
    int         exp_score;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] letter_of(input logic [2:0] r);
    case (r)
      3'b100:  return 8'h50;
      3'b010:  return 8'h47;
      3'b001:  return 8'h42;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic int inc_of(input logic [2:0] r);
    case (r)
      3'b100:  return 3;
      3'b010:  return 1;
      default: return 0;
    endcase
  endfunction

  // receiver: samples mid-bit on falling edges
  logic [7:0] rx_d;
  logic       rx_p;
  logic       rx_stop;
  logic [7:0] rx_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          rx_d[i] = tx;
        end
`ifdef RESULT_UART_PARITY_EN
        repeat (B) @(negedge clk);
        rx_p = tx;
`endif
        repeat (B) @(negedge clk);
        rx_stop = tx;
        if (mon_en) begin
          if (sbq.size() == 0) begin
            check("rx_unexpected_byte", rx_d, -1);
          end else begin
            rx_exp = sbq.pop_front();
            check("rx_byte", rx_d, rx_exp);
          end
          check("rx_stop", rx_stop, 1);
`ifdef RESULT_UART_PARITY_EN
          check("rx_parity", rx_p, ^rx_d);
`endif
        end
      end
    end
  end

  task automatic start_tx(input logic [2:0] r, input logic clr);
    int s;
    @(negedge clk);
    result      = r;
    clear_score = clr;
    uart_start  = 1'b1;
    if (clr) model_score = 0;
    model_score = model_score + inc_of(r);
    if (model_score > 99) model_score = 99;
    s = model_score;
    sbq.push_back(letter_of(r));
    sbq.push_back(8'(48 + s / 10));
    sbq.push_back(8'(48 + s % 10));
    sbq.push_back(8'h0A);
    @(negedge clk);
    uart_start  = 1'b0;
    clear_score = 1'b0;
    check("busy_at_load", busy, 1);
    check("score_at_load", score, model_score);
    check("no_overrun_on_accept", overrun, 0);
  endtask

  // counts busy cycles; start_cnt = busy cycles already elapsed before the current one
  task automatic wait_done(input int start_cnt, input int ovr_at);
    int cnt;
    cnt = start_cnt;
    while (busy && cnt < FRAME_CYC + 20) begin
      cnt++;
      if (cnt == ovr_at) begin
        uart_start = 1'b1;
        result     = 3'b010;
      end else if (ovr_at > 0 && cnt == ovr_at + 1) begin
        uart_start = 1'b0;
        check("overrun_pulse", overrun, 1);
      end else if (ovr_at > 0 && cnt == ovr_at + 2) begin
        check("overrun_one_cycle", overrun, 0);
      end
      @(negedge clk);
    end
    check("busy_len", cnt, FRAME_CYC);
  endtask

  initial begin
    reset       = 1'b0;
    result      = 3'b000;
    uart_start  = 1'b0;
    clear_score = 1'b0;

    tbl[0] = '{3'b100, 1'b0, 3};
    tbl[1] = '{3'b010, 1'b0, 4};
    tbl[2] = '{3'b010, 1'b0, 5};
    tbl[3] = '{3'b001, 1'b0, 5};
    tbl[4] = '{3'b011, 1'b0, 5};
    tbl[5] = '{3'b010, 1'b1, 1};
    tbl[6] = '{3'b000, 1'b0, 1};
    tbl[7] = '{3'b100, 1'b0, 4};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_score", score, 0);
    check("rst_overrun", overrun, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_tx(tbl[i].res, tbl[i].clr);
      check($sformatf("tbl%0d_score", i), score, tbl[i].exp_score);
      wait_done(0, 0);
    end

    // strobe while busy: dropped, overrun pulses, score untouched (4 -> 7 from the accepted Perfect)
    start_tx(3'b100, 1'b0);
    wait_done(0, 50);
    check("score_after_overrun", score, 7);

`ifdef RESULT_UART_PARITY_EN
    start_tx(3'b010, 1'b0);
    repeat (76) @(negedge clk);
    check("parity_0x47", tx, 0);
    wait_done(76, 0);
`endif

    // reset during DATA of the first byte
    start_tx(3'b010, 1'b0);
    repeat (38) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_score", score, 0);
    reset       = 1'b1;
    model_score = 0;
    sbq.delete();
    repeat (12 * B) @(negedge clk);
    check("abort_line_idle", tx, 1);
    mon_en = 1'b1;

    for (int k = 0; k < 34; k++) begin
      start_tx(3'b100, 1'b0);
      check($sformatf("sat%0d_score", k), score, (3 * (k + 1) > 99) ? 99 : 3 * (k + 1));
      wait_done(0, 0);
    end
    repeat (4) @(negedge clk);
    check("sat_final_score", score, 99);
    check("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
